// File: rtl/mult_div_unit.sv
// Sequential signed multiply/divide unit for the multicycle MIPS datapath.
// The operation runs on operand magnitudes, one iteration per cycle, and the
// signs are applied in a final SIGN cycle. Results are held in HI/LO.
//
// state  | meaning
// -------+------------------------------------------------------------
// S_IDLE | waiting for start; HI/LO hold their last value
// S_RUN  | WIDTH iterations of shift-add (mult) or restoring divide (div)
// S_SIGN | apply result signs and load HI/LO
// S_DONE | done pulse for one cycle; a new start is accepted here
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_SIGN, S_DONE} state_t;

  state_t             state_q;
  logic [CW-1:0]      cnt_q;
  logic [WIDTH-1:0]   mag_a_q, mag_b_q;
  logic               sign_a_q, sign_b_q, op_q;
  logic [2*WIDTH-1:0] prod_q;
  logic [WIDTH:0]     rem_q;
  logic [WIDTH-1:0]   quo_q;
  logic               busy_q, done_q, div_zero_q;
  logic [WIDTH-1:0]   hi_q, lo_q;

  logic [WIDTH-1:0]   mag_a_d, mag_b_d;
  logic [WIDTH:0]     prod_sum_d;
  logic [2*WIDTH-1:0] prod_d;
  logic [WIDTH+1:0]   trial_d;
  logic [WIDTH:0]     rem_d;
  logic [WIDTH-1:0]   quo_d;
  logic [2*WIDTH-1:0] prod_fix_d;
  logic [WIDTH-1:0]   quo_fix_d, rem_fix_d;

  // Operand magnitudes, one iteration step of each algorithm, and sign fix-up.
  // The most negative operand maps to its own bit pattern, read as unsigned.
  always_comb begin
    mag_a_d    = a[WIDTH-1] ? -a : a;
    mag_b_d    = b[WIDTH-1] ? -b : b;

    // shift-add: multiplier sits in the low half and shifts out as product bits enter
    prod_sum_d = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + {1'b0, (prod_q[0] ? mag_a_q : '0)};
    prod_d     = {prod_sum_d, prod_q[WIDTH-1:1]};

    // restoring divide: dividend shifts out of quo_q while quotient bits shift in
    trial_d    = {rem_q, quo_q[WIDTH-1]} - {2'b00, mag_b_q};
    rem_d      = trial_d[WIDTH+1] ? {rem_q[WIDTH-1:0], quo_q[WIDTH-1]} : trial_d[WIDTH:0];
    quo_d      = {quo_q[WIDTH-2:0], ~trial_d[WIDTH+1]};

    prod_fix_d = (sign_a_q ^ sign_b_q) ? -prod_q : prod_q;
    quo_fix_d  = (sign_a_q ^ sign_b_q) ? -quo_q : quo_q;
    rem_fix_d  = sign_a_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];
  end

  // Control FSM with registered status outputs and datapath registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      mag_a_q    <= '0;
      mag_b_q    <= '0;
      sign_a_q   <= 1'b0;
      sign_b_q   <= 1'b0;
      op_q       <= 1'b0;
      prod_q     <= '0;
      rem_q      <= '0;
      quo_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          done_q <= 1'b0;
          if (start) begin
            op_q       <= op;
            sign_a_q   <= a[WIDTH-1];
            sign_b_q   <= b[WIDTH-1];
            mag_a_q    <= mag_a_d;
            mag_b_q    <= mag_b_d;
            cnt_q      <= '0;
            prod_q     <= {{WIDTH{1'b0}}, mag_b_d};
            rem_q      <= '0;
            quo_q      <= mag_a_d;
            if (op && (b == '0)) begin
              // divide by zero: report immediately, HI/LO untouched
              state_q    <= S_DONE;
              div_zero_q <= 1'b1;
              done_q     <= 1'b1;
              busy_q     <= 1'b0;
            end else begin
              state_q    <= S_RUN;
              div_zero_q <= 1'b0;
              busy_q     <= 1'b1;
            end
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_RUN: begin
          cnt_q <= cnt_q + CW'(1);
          if (op_q) begin
            rem_q <= rem_d;
            quo_q <= quo_d;
          end else begin
            prod_q <= prod_d;
          end
          if (cnt_q == CW'(WIDTH-1)) state_q <= S_SIGN;
        end
        S_SIGN: begin
          if (op_q) begin
            hi_q <= rem_fix_d;
            lo_q <= quo_fix_d;
          end else begin
            hi_q <= prod_fix_d[2*WIDTH-1:WIDTH];
            lo_q <= prod_fix_d[WIDTH-1:0];
          end
          state_q <= S_DONE;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign div_zero = div_zero_q;
  assign hi       = hi_q;
  assign lo       = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: latency, signed results, divide by zero,
// ignored/back-to-back starts and asynchronous reset mid-operation.
module tb_mult_div_unit;

  logic        clock = 1'b0;
  logic        reset, start, op;
  logic [31:0] a, b;
  logic        busy, done, div_zero;
  logic [31:0] hi, lo;

  int total = 0;
  int bad   = 0;

  mult_div_unit #(.WIDTH(32)) dut (
    .clock(clock), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .div_zero(div_zero), .hi(hi), .lo(lo)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic o, input logic [31:0] x, input logic [31:0] y);
    start = 1'b1;
    op    = o;
    a     = x;
    b     = y;
  endtask

  // Called at a negedge; start is sampled in cycle 0, lat is the cycle done is seen.
  task automatic run_op(input logic o, input logic [31:0] x, input logic [31:0] y,
                        output int lat, output int busy_cyc);
    @(negedge clock);
    drive(o, x, y);
    @(negedge clock);
    start    = 1'b0;
    lat      = 1;
    busy_cyc = 0;
    while (!done && lat < 100) begin
      if (busy) busy_cyc++;
      @(negedge clock);
      lat++;
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat, bc, c, ndone;
    reset = 1'b1; start = 1'b0; op = 1'b0; a = '0; b = '0;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_dz",   64'(div_zero), 64'd0);
    chk("rst_hi",   64'(hi), 64'd0);
    chk("rst_lo",   64'(lo), 64'd0);

    // mult 7 * -3 = -21
    run_op(1'b0, 32'd7, 32'hFFFFFFFD, lat, bc);
    chk("m1_lat",  64'(lat), 64'd34);
    chk("m1_busy", 64'(bc), 64'd33);
    chk("m1_hi",   64'(hi), 64'hFFFFFFFF);
    chk("m1_lo",   64'(lo), 64'hFFFFFFEB);
    @(negedge clock);
    chk("m1_done_once", 64'(done), 64'd0);
    chk("m1_idle_busy", 64'(busy), 64'd0);

    // div -7 / 2 = -3 rem -1
    run_op(1'b1, 32'hFFFFFFF9, 32'd2, lat, bc);
    chk("d1_lat", 64'(lat), 64'd34);
    chk("d1_lo",  64'(lo), 64'hFFFFFFFD);
    chk("d1_hi",  64'(hi), 64'hFFFFFFFF);
    chk("d1_dz",  64'(div_zero), 64'd0);

    // div 100 / 7 = 14 rem 2
    run_op(1'b1, 32'd100, 32'd7, lat, bc);
    chk("d2_lo", 64'(lo), 64'd14);
    chk("d2_hi", 64'(hi), 64'd2);

    // mult 0x80000000 * 0x80000000 = 2^62
    run_op(1'b0, 32'h80000000, 32'h80000000, lat, bc);
    chk("m2_hi", 64'(hi), 64'h40000000);
    chk("m2_lo", 64'(lo), 64'h0);

    // overflow divide
    run_op(1'b1, 32'h80000000, 32'hFFFFFFFF, lat, bc);
    chk("d3_lo", 64'(lo), 64'h80000000);
    chk("d3_hi", 64'(hi), 64'h0);
    chk("d3_dz", 64'(div_zero), 64'd0);

    // preload hi=0x12, lo=0x34 via 0x3412 / 0x100
    run_op(1'b1, 32'h3412, 32'h100, lat, bc);
    chk("pre_hi", 64'(hi), 64'h12);
    chk("pre_lo", 64'(lo), 64'h34);

    // divide by zero
    run_op(1'b1, 32'd5, 32'd0, lat, bc);
    chk("dz_lat",  64'(lat), 64'd1);
    chk("dz_flag", 64'(div_zero), 64'd1);
    chk("dz_hi",   64'(hi), 64'h12);
    chk("dz_lo",   64'(lo), 64'h34);
    @(negedge clock);
    chk("dz_done_once", 64'(done), 64'd0);
    chk("dz_held",      64'(div_zero), 64'd1);
    chk("dz_hi_held",   64'(hi), 64'h12);

    // next accepted start clears div_zero
    @(negedge clock);
    drive(1'b0, 32'd3, 32'd4);
    @(negedge clock);
    start = 1'b0;
    chk("dz_clear", 64'(div_zero), 64'd0);
    c = 1;
    while (!done && c < 100) begin
      @(negedge clock);
      c++;
    end
    chk("m3_lat", 64'(c), 64'd34);
    chk("m3_lo",  64'(lo), 64'd12);
    chk("m3_hi",  64'(hi), 64'd0);

    // start during RUN ignored
    @(negedge clock);
    drive(1'b0, 32'h12345, 32'h100);
    @(negedge clock);
    start = 1'b0;
    c = 1;
    while (!done && c < 100) begin
      if (c == 10) drive(1'b1, 32'd1, 32'd1);
      else start = 1'b0;
      @(negedge clock);
      c++;
    end
    chk("ign_lat", 64'(c), 64'd34);
    chk("ign_hi",  64'(hi), 64'h0);
    chk("ign_lo",  64'(lo), 64'h01234500);

    // back-to-back: start in the DONE cycle
    drive(1'b0, 32'hFFFFFFFE, 32'd5);
    @(negedge clock);
    start = 1'b0;
    c = 1;
    while (!done && c < 100) begin
      @(negedge clock);
      c++;
    end
    chk("b2b_lat", 64'(c), 64'd34);
    chk("b2b_hi",  64'(hi), 64'hFFFFFFFF);
    chk("b2b_lo",  64'(lo), 64'hFFFFFFF6);

    // asynchronous reset in cycle 15 of a divide
    @(negedge clock);
    drive(1'b1, 32'd100, 32'd7);
    @(negedge clock);
    start = 1'b0;
    c = 1;
    while (c < 15) begin
      @(negedge clock);
      c++;
    end
    chk("ar_busy_before", 64'(busy), 64'd1);
    #2 reset = 1'b1;
    #1;
    chk("ar_busy", 64'(busy), 64'd0);
    chk("ar_done", 64'(done), 64'd0);
    chk("ar_dz",   64'(div_zero), 64'd0);
    chk("ar_hi",   64'(hi), 64'd0);
    chk("ar_lo",   64'(lo), 64'd0);
    @(negedge clock);
    reset = 1'b0;
    ndone = 0;
    repeat (40) begin
      @(negedge clock);
      if (done) ndone++;
    end
    chk("ar_no_done", 64'(ndone), 64'd0);
    run_op(1'b0, 32'd6, 32'd7, lat, bc);
    chk("ar_m_lat", 64'(lat), 64'd34);
    chk("ar_m_lo",  64'(lo), 64'd42);
    chk("ar_m_hi",  64'(hi), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
